// File: rtl/orb_wr_pkg.sv
// Shared constants and the queue entry type for the orbit RAM write arbiter.
package orb_wr_pkg;

    localparam int N_REQ  = 4;
    localparam int ADDR_W = 11;
    localparam int DATA_W = 12;
    localparam int DEPTH  = 2;

    localparam int REQ_FAST1 = 0;
    localparam int REQ_FAST2 = 1;
    localparam int REQ_SLOW1 = 2;
    localparam int REQ_SLOW2 = 3;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] word;
        logic              tag;
    } orb_entry_t;

endpackage

// File: rtl/orb_wr_slot.sv
// One requester queue: a DEPTH-entry FIFO whose head falls through from the
// push port when empty, so an uncontested word can be granted in its own cycle.
module orb_wr_slot #(
    parameter int W     = 24,
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] head,
    output logic         valid,
    output logic         full,
    output logic         occupied
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [DEPTH-1:0][W-1:0] mem_q, mem_d;
    logic [PW-1:0]           wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0]           count_q, count_d;
    logic                    empty, push_ok, bypass, store, take;

    always_comb begin
        empty    = (count_q == '0);
        full     = (count_q == CW'(DEPTH));
        occupied = !empty;
        valid    = !empty || push;
        head     = empty ? push_data : mem_q[rd_q];
        push_ok  = push && (!full || pop);
        // A word popped in the cycle it arrives at an empty queue is never stored.
        bypass   = empty && push && pop;
        store    = push_ok && !bypass;
        take     = pop && !empty;

        mem_d   = mem_q;
        wr_d    = wr_q;
        rd_d    = rd_q;
        count_d = count_q + CW'(store) - CW'(take);
        if (store) begin
            mem_d[wr_q] = push_data;
            wr_d        = wr_q + 1'b1;
        end
        if (take) rd_d = rd_q + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q   <= '0;
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            mem_q   <= mem_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/orb_wr_arbiter.sv
// Round-robin write scheduler for the ping-pong orbit RAM pair: per-requester
// queues, stale-bank discard, one registered RAM write per clock.
module orb_wr_arbiter
    import orb_wr_pkg::*;
#(
    parameter int N_REQ  = orb_wr_pkg::N_REQ,
    parameter int ADDR_W = orb_wr_pkg::ADDR_W,
    parameter int DATA_W = orb_wr_pkg::DATA_W,
    parameter int DEPTH  = orb_wr_pkg::DEPTH
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    SW,
    input  logic [N_REQ-1:0]        iWE,
    input  logic [N_REQ*ADDR_W-1:0] iAddr,
    input  logic [N_REQ*DATA_W-1:0] iWord,
    output logic                    oWE1,
    output logic                    oWE2,
    output logic [ADDR_W-1:0]       oAddr,
    output logic [DATA_W-1:0]       oWord,
    output logic                    oBusy,
    output logic [N_REQ-1:0]        oOverflow,
    output logic [7:0]              oDropCnt
);

    localparam int RW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int EW = $bits(orb_entry_t);

    orb_entry_t [N_REQ-1:0] in_e, head_e;
    orb_entry_t             gnt_e;
    logic [N_REQ-1:0]       vld, full, occ, stale, elig, pop, drop_ovf;
    logic [RW-1:0]          rr_q, rr_d, gnt_idx;
    logic                   gnt_vld;
    logic [3:0]             n_drop;
    logic [8:0]             drop_sum;

    logic                   we1_q, we1_d, we2_q, we2_d;
    logic [ADDR_W-1:0]      addr_q, addr_d;
    logic [DATA_W-1:0]      word_q, word_d;
    logic [N_REQ-1:0]       ovf_q, ovf_d;
    logic [7:0]             drop_q, drop_d;

    for (genvar k = 0; k < N_REQ; k++) begin : g_slot
        assign in_e[k] = '{addr: iAddr[k*ADDR_W +: ADDR_W],
                           word: iWord[k*DATA_W +: DATA_W],
                           tag:  SW};

        orb_wr_slot #(.W(EW), .DEPTH(DEPTH)) u_slot (
            .clk       (clk),
            .rst       (rst),
            .push      (iWE[k]),
            .push_data (in_e[k]),
            .pop       (pop[k]),
            .head      (head_e[k]),
            .valid     (vld[k]),
            .full      (full[k]),
            .occupied  (occ[k])
        );
    end

    always_comb begin
        int j;
        j       = 0;
        gnt_vld = 1'b0;
        gnt_idx = '0;
        // Tag compares against the live SW so a bank swap retires old heads at once.
        for (int k = 0; k < N_REQ; k++) begin
            stale[k] = vld[k] && (head_e[k].tag != SW);
            elig[k]  = vld[k] && !stale[k];
        end
        for (int i = 0; i < N_REQ; i++) begin
            j = (int'(rr_q) + i) % N_REQ;
            if (!gnt_vld && elig[j]) begin
                gnt_vld = 1'b1;
                gnt_idx = RW'(j);
            end
        end
        gnt_e  = head_e[gnt_idx];
        n_drop = '0;
        for (int k = 0; k < N_REQ; k++) begin
            pop[k]      = stale[k] || (gnt_vld && gnt_idx == RW'(k));
            drop_ovf[k] = iWE[k] && full[k] && !pop[k];
            n_drop      = n_drop + 4'(drop_ovf[k]) + 4'(stale[k]);
        end

        rr_d = rr_q;
        if (gnt_vld) rr_d = (int'(gnt_idx) == N_REQ - 1) ? '0 : gnt_idx + 1'b1;

        we1_d    = gnt_vld && SW;
        we2_d    = gnt_vld && !SW;
        addr_d   = gnt_vld ? gnt_e.addr : addr_q;
        word_d   = gnt_vld ? gnt_e.word : word_q;
        ovf_d    = ovf_q | drop_ovf;
        drop_sum = {1'b0, drop_q} + 9'(n_drop);
        drop_d   = drop_sum[8] ? 8'hFF : drop_sum[7:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_q   <= '0;
            we1_q  <= 1'b0;
            we2_q  <= 1'b0;
            addr_q <= '0;
            word_q <= '0;
            ovf_q  <= '0;
            drop_q <= '0;
        end else begin
            rr_q   <= rr_d;
            we1_q  <= we1_d;
            we2_q  <= we2_d;
            addr_q <= addr_d;
            word_q <= word_d;
            ovf_q  <= ovf_d;
            drop_q <= drop_d;
        end
    end

    assign oWE1      = we1_q;
    assign oWE2      = we2_q;
    assign oAddr     = addr_q;
    assign oWord     = word_q;
    assign oOverflow = ovf_q;
    assign oDropCnt  = drop_q;
    assign oBusy     = |occ;

endmodule

// File: tb/tb_orb_wr_arbiter.sv
// Directed bench for orb_wr_arbiter: single write, burst, stale, overflow,
// round-robin fairness with drop saturation, and reset mid-burst.
module tb_orb_wr_arbiter;
    import orb_wr_pkg::*;

    logic clk = 1'b0;
    logic rst;
    logic SW;
    logic [N_REQ-1:0]             iWE;
    logic [N_REQ-1:0][ADDR_W-1:0] a;
    logic [N_REQ-1:0][DATA_W-1:0] w;
    logic                         oWE1, oWE2, oBusy;
    logic [ADDR_W-1:0]            oAddr;
    logic [DATA_W-1:0]            oWord;
    logic [N_REQ-1:0]             oOverflow;
    logic [7:0]                   oDropCnt;

    int checks   = 0;
    int failures = 0;
    int exp_g;

    always #5 clk = ~clk;

    orb_wr_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .SW        (SW),
        .iWE       (iWE),
        .iAddr     (a),
        .iWord     (w),
        .oWE1      (oWE1),
        .oWE2      (oWE2),
        .oAddr     (oAddr),
        .oWord     (oWord),
        .oBusy     (oBusy),
        .oOverflow (oOverflow),
        .oDropCnt  (oDropCnt)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        iWE = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    initial begin
        SW  = 1'b0;
        iWE = '0;
        a   = '0;
        w   = '0;
        rst = 1'b1;
        tick();
        chk("rst_we1", oWE1, 0);
        chk("rst_we2", oWE2, 0);
        chk("rst_busy", oBusy, 0);
        chk("rst_addr", oAddr, 0);
        chk("rst_word", oWord, 0);
        chk("rst_ovf", oOverflow, 0);
        chk("rst_drop", oDropCnt, 0);
        do_reset();

        // single uncontested write
        SW = 1'b1; iWE = 4'b0001; a[0] = 11'h010; w[0] = 12'hABC;
        tick();
        iWE = '0;
        chk("single_we1", oWE1, 1);
        chk("single_we2", oWE2, 0);
        chk("single_addr", oAddr, 11'h010);
        chk("single_word", oWord, 12'hABC);
        chk("single_busy", oBusy, 0);
        tick();
        chk("single_we1_off", oWE1, 0);
        chk("single_hold_addr", oAddr, 11'h010);
        do_reset();

        // four simultaneous pulses drain 0,1,2,3
        SW = 1'b0; iWE = 4'b1111;
        for (int k = 0; k < N_REQ; k++) begin
            a[k] = 11'(11'h100 + k);
            w[k] = 12'(12'h500 + k);
        end
        for (int k = 0; k < N_REQ; k++) begin
            tick();
            iWE = '0;
            chk("burst_we2", oWE2, 1);
            chk("burst_we1", oWE1, 0);
            chk("burst_addr", oAddr, 32'h100 + k);
            chk("burst_word", oWord, 32'h500 + k);
        end
        tick();
        chk("burst_idle", oWE2, 0);
        chk("burst_busy", oBusy, 0);
        chk("burst_drop", oDropCnt, 0);

        // stale: two SW=1 entries parked in queue 3, then the bank swaps
        SW = 1'b1; iWE = 4'b1011;
        a[0] = 11'h200; a[1] = 11'h201; a[3] = 11'h203;
        tick();
        chk("stale_g0", oAddr, 11'h200);
        chk("stale_g0_we1", oWE1, 1);
        iWE = 4'b1000; a[3] = 11'h2F3;
        tick();
        chk("stale_g1", oAddr, 11'h201);
        SW = 1'b0; iWE = '0;
        tick();
        chk("stale_no_we1", oWE1, 0);
        chk("stale_no_we2", oWE2, 0);
        chk("stale_drop1", oDropCnt, 1);
        chk("stale_busy", oBusy, 1);
        tick();
        chk("stale_no_we2_b", oWE2, 0);
        chk("stale_drop2", oDropCnt, 2);
        chk("stale_empty", oBusy, 0);
        iWE = 4'b1000; a[3] = 11'h2AA;
        tick();
        iWE = '0;
        chk("stale_new_we2", oWE2, 1);
        chk("stale_new_addr", oAddr, 11'h2AA);

        // overflow on queue 2: pre-roll the pointer to 3, then fill queue 2
        iWE = 4'b0100; a[2] = 11'h300;
        tick();
        chk("ovf_pre", oAddr, 11'h300);
        iWE = 4'b1111;
        for (int k = 0; k < N_REQ; k++) a[k] = 11'(11'h310 + k);
        tick();
        chk("ovf_g3", oAddr, 11'h313);
        iWE = 4'b0100; a[2] = 11'h320;
        tick();
        chk("ovf_g0", oAddr, 11'h310);
        chk("ovf_none_yet", oOverflow, 0);
        a[2] = 11'h330;
        tick();
        iWE = '0;
        chk("ovf_g1", oAddr, 11'h311);
        chk("ovf_flag", oOverflow, 4'b0100);
        chk("ovf_drop", oDropCnt, 3);
        tick();
        chk("ovf_g2a", oAddr, 11'h312);
        tick();
        chk("ovf_g2b", oAddr, 11'h320);
        tick();
        chk("ovf_idle", oWE2, 0);
        chk("ovf_busy", oBusy, 0);
        repeat (5) tick();
        chk("ovf_sticky", oOverflow, 4'b0100);
        chk("ovf_drop_hold", oDropCnt, 3);
        do_reset();
        chk("ovf_cleared", oOverflow, 0);
        chk("drop_cleared", oDropCnt, 0);

        // fairness: everyone pulses every cycle; drops run into saturation
        SW = 1'b0; exp_g = 0;
        for (int c = 0; c < 90; c++) begin
            iWE = 4'b1111;
            for (int k = 0; k < N_REQ; k++) begin
                a[k] = {1'b0, 2'(k), 8'(c)};
                w[k] = 12'(c);
            end
            tick();
            chk("fair_we2", oWE2, 1);
            chk("fair_gnt", oAddr[9:8], exp_g);
            exp_g = (exp_g + 1) % N_REQ;
            if (c == 39) chk("fair_drop40", oDropCnt, 112);
        end
        iWE = '0;
        for (int c = 0; c < 2 * N_REQ; c++) begin
            tick();
            chk("drain_we2", oWE2, 1);
            chk("drain_gnt", oAddr[9:8], exp_g);
            exp_g = (exp_g + 1) % N_REQ;
        end
        tick();
        chk("fair_idle", oWE2, 0);
        chk("fair_busy", oBusy, 0);
        chk("fair_drop_sat", oDropCnt, 255);
        chk("fair_ovf", oOverflow, 4'b1111);
        do_reset();

        // reset mid-burst cancels the pending write and flushes queues
        SW = 1'b1; iWE = 4'b1111;
        for (int k = 0; k < N_REQ; k++) a[k] = 11'(11'h400 + k);
        tick();
        iWE = '0;
        chk("mid_we1", oWE1, 1);
        chk("mid_busy", oBusy, 1);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_we1", oWE1, 0);
        chk("mid_rst_we2", oWE2, 0);
        chk("mid_rst_busy", oBusy, 0);
        chk("mid_rst_addr", oAddr, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("post_rst_we1", oWE1, 0);
            chk("post_rst_we2", oWE2, 0);
        end
        iWE = 4'b0010; a[REQ_FAST2] = 11'h455;
        tick();
        iWE = '0;
        chk("post_rst_new_we1", oWE1, 1);
        chk("post_rst_new_addr", oAddr, 11'h455);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/orb_wr_arbiter.md
# orb_wr_arbiter

Write-port arbiter and scheduler for the two ping-pong orbit frame RAMs (ramM16 pair). It accepts single-cycle write requests from up to four packers (two fast, two slow) that may fire in the same cycle. Each request is buffered in a small per-requester queue, and the queues are drained round-robin at one RAM write per clock. Each write is steered to the bank not currently being read by M16. The block replaces the combinational priority mux on the orbit RAM write port, which silently lost simultaneous writes.

## Interface
Parameters:
- N_REQ, 4, number of requesters (fast1, fast2, slow1, slow2 in that index order)
- ADDR_W, 11, orbit RAM address width
- DATA_W, 12, orbit word width
- DEPTH, 2, entries per requester queue (power of two)

Ports:
- clk  in  1  system clock (80 MHz domain); one clock; reset is asynchronous and active-high
- rst  in  1  asynchronous, active-high reset
- SW  in  1  bank select from M16, already synchronized to clk; SW=1: write RAM1, SW=0: write RAM2
- iWE  in  N_REQ  per-requester write strobe, one-cycle pulse per word
- iAddr  in  N_REQ*ADDR_W  packed addresses; requester k occupies bits [k*ADDR_W +: ADDR_W]
- iWord  in  N_REQ*DATA_W  packed words, same packing
- oWE1  out  1  write enable, RAM1
- oWE2  out  1  write enable, RAM2
- oAddr  out  ADDR_W  shared write address
- oWord  out  DATA_W  shared write data
- oBusy  out  1  any queue non-empty
- oOverflow  out  N_REQ  sticky per-requester overflow flags; cleared only by rst
- oDropCnt  out  8  saturating count of all discarded words (overflow plus stale)

## Operation
- Capture: when iWE[k]=1, push {iAddr_k, iWord_k, tag=SW} into queue k.
- Overflow: if queue k is full and is not popped in the same cycle, the push is dropped, oOverflow[k] is set, and oDropCnt increments. Push and pop in the same cycle on a full queue is accepted.
- Stale discard: an entry whose tag differs from the current SW is at its head. It is popped without a write, and oDropCnt increments. At most one stale pop per queue per cycle.
- Grant: round-robin among queues whose head is valid and not stale. The pointer advances to granted+1 mod N_REQ. When nothing is granted, the pointer holds.
- Only one RAM write per cycle. Stale pops of non-granted queues proceed in parallel.
- Output register: oWE1 = granted & SW, oWE2 = granted & ~SW. oAddr and oWord are loaded from the granted head. When there is no grant, oWE1 and oWE2 are 0 and oAddr and oWord hold their previous values.
- oDropCnt saturates at 255. Multiple discards in one cycle add their full count, capped at 255.
- No state machine beyond the queue pointers and the RR pointer. The block is fully pipelined.

## Timing
- Reset values:
  - all queues empty
  - RR pointer 0
  - oWE1, oWE2, oBusy, oOverflow = 0
  - oAddr, oWord, oDropCnt = 0
- Latency: with an uncontested request at cycle n, oWEx is high at cycle n+1. The worst case with all four queues full is 4*DEPTH cycles.
- Throughput: 1 word/clk sustained. Four simultaneous pulses drain in 4 cycles, in order 0,1,2,3 from pointer 0.
- A SW toggle at cycle n takes effect for grants evaluated in cycle n. An entry pushed in the same cycle as the toggle carries the new SW value.
- rst mid-operation: queues are flushed and any pending output write is cancelled asynchronously. No partial write follows deassertion.
- oBusy is combinational from the queue occupancy registers, not from the output register.

## Structure
- Package orb_wr_pkg holds:
  - ADDR_W, DATA_W, N_REQ, DEPTH constants
  - the entry typedef {addr, word, tag}
  - requester index constants REQ_FAST1..REQ_SLOW2
- Sub-module orb_wr_slot: one DEPTH-entry FIFO with push, pop, head, valid and full. It is instantiated N_REQ times.
- The RR grant and stale logic live in the top module.

## Test plan
- Single write: SW=1, iWE=0001, addr 0x010, word 0xABC. Required at the next cycle: oWE1=1, oWE2=0, oAddr=0x010, oWord=0xABC. oBusy is 0 afterwards.
- Simultaneous burst: iWE=1111 in one cycle, addresses 0x100..0x103, SW=0. Required: four consecutive oWE2 pulses with addresses 0x100, 0x101, 0x102, 0x103, and oDropCnt=0.
- Overflow: requester 2 pulses on 3 consecutive cycles while requesters 0, 1 and 3 are each kept busy. Required: one word dropped, oOverflow=0100, oDropCnt=1, and the flag stays set until rst.
- Stale: queue 3 holds 2 entries tagged SW=1 and SW toggles to 0 before they are granted. Required: no oWE1 or oWE2 for those entries, oDropCnt increments by 2, and a new SW=0 entry then writes via oWE2.
- Fairness: all four requesters pulse every cycle for 40 cycles. Required: grants rotate 0,1,2,3 with no requester skipped, and drops are counted per the overflow rule.
- Reset mid-burst: assert rst with 3 entries queued. Required: immediately after assertion, outputs are 0 and oBusy=0. After release, no write occurs until a new iWE.
